// File: rtl/alu_pkg.sv
// Shared ALU opcodes and the arbiter's FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_NAND = 4'b0111;
  localparam logic [3:0] ALU_XNOR = 4'b1000;
  localparam logic [3:0] ALU_SHL  = 4'b1001;
  localparam logic [3:0] ALU_SHR  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Carry is the adder carry-out (for SUB: 1 = no borrow);
// undefined opcodes pass d1 through with carry 0.
module alu
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 64
) (
  input  logic [3:0]           opcode,
  input  logic [WORD_SIZE-1:0] d1,
  input  logic [WORD_SIZE-1:0] d2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 iszero,
  output logic                 iscarry
);

  localparam int SH_W = $clog2(WORD_SIZE);

  logic [WORD_SIZE:0] ext;

  always_comb begin
    ext     = '0;
    out     = d1;
    iscarry = 1'b0;
    case (opcode)
      ALU_ADD: begin
        ext     = {1'b0, d1} + {1'b0, d2};
        out     = ext[WORD_SIZE-1:0];
        iscarry = ext[WORD_SIZE];
      end
      ALU_SUB: begin
        ext     = {1'b0, d1} + {1'b0, ~d2} + (WORD_SIZE+1)'(1);
        out     = ext[WORD_SIZE-1:0];
        iscarry = ext[WORD_SIZE];
      end
      ALU_MUL:  out = d1 * d2;
      ALU_OR:   out = d1 | d2;
      ALU_AND:  out = d1 & d2;
      ALU_XOR:  out = d1 ^ d2;
      ALU_NOR:  out = ~(d1 | d2);
      ALU_NAND: out = ~(d1 & d2);
      ALU_XNOR: out = ~(d1 ^ d2);
      ALU_SHL:  out = d1 << d2[SH_W-1:0];
      ALU_SHR:  out = d1 >> d2[SH_W-1:0];
      default:  out = d1;
    endcase
  end

  assign iszero = (out == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[ID_W'((int'(ptr) + i) % NUM_REQ)]) begin
        any = 1'b1;
        grant[ID_W'((int'(ptr) + i) % NUM_REQ)] = 1'b1;
        grant_id = ID_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters; response 2 cycles after grant, held until rsp_ready.
// Define ALU_ARB_FLAGS_EN to add the rsp_zero/rsp_carry outputs.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int WORD_SIZE = 64,
  parameter  int NUM_REQ   = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_d1,
  input  logic [NUM_REQ*WORD_SIZE-1:0] req_d2,
  input  logic [NUM_REQ*4-1:0]         req_opcode,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [WORD_SIZE-1:0]         rsp_data
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic                         rsp_zero,
  output logic                         rsp_carry
`endif
);

  arb_state_t           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_REQ-1:0]   grant;
  logic                 any;
  logic [ID_W-1:0]      op_id;
  logic [WORD_SIZE-1:0] op_d1, op_d2;
  logic [3:0]           op_code;
  logic [WORD_SIZE-1:0] sel_d1, sel_d2;
  logic [3:0]           sel_code;
  logic [WORD_SIZE-1:0] alu_out;
`ifdef ALU_ARB_FLAGS_EN
  logic                 alu_zero, alu_carry;
`else
  logic                 zero_unused, carry_unused;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
    .opcode  (op_code),
    .d1      (op_d1),
    .d2      (op_d2),
    .out     (alu_out),
`ifdef ALU_ARB_FLAGS_EN
    .iszero  (alu_zero),
    .iscarry (alu_carry)
`else
    .iszero  (zero_unused),
    .iscarry (carry_unused)
`endif
  );

  // Reset masks the grant so it always wins over a same-cycle handshake.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;

  always_comb begin
    sel_d1   = '0;
    sel_d2   = '0;
    sel_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_d1   = req_d1[i*WORD_SIZE +: WORD_SIZE];
        sel_d2   = req_d2[i*WORD_SIZE +: WORD_SIZE];
        sel_code = req_opcode[i*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      op_id     <= '0;
      op_d1     <= '0;
      op_d2     <= '0;
      op_code   <= ALU_ADD;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            op_d1   <= sel_d1;
            op_d2   <= sel_d2;
            op_code <= sel_code;
            op_id   <= grant_id;
            rr_ptr  <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data  <= alu_out;
          rsp_id    <= op_id;
`ifdef ALU_ARB_FLAGS_EN
          rsp_zero  <= alu_zero;
          rsp_carry <= alu_carry;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
